// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: preloads data memory, runs the processor until halt or timeout, then streams a memory window out.
// Define PROG_RUN_CTRL_CLEAR_EN to zero all 256 memory bytes before each preload.
module prog_run_ctrl #(
    parameter int          DUMP_BASE  = 30,
    parameter int          DUMP_LEN   = 30,
    parameter int          START_HOLD = 2,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        go,
    input  logic        ld_valid,
    input  logic        ld_last,
    input  logic [7:0]  ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dut_start,
    input  logic        dut_halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_addr,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycles
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, START, RUN, DUMP, DONE} state_t;
    state_t state, state_nx;
    // cnt is the clear address, the start-hold counter or the dump index depending on state
    logic [15:0] cnt;
    logic [7:0] dump_addr;
    logic hold_end, dump_end, run_cap;
    assign dump_addr = 8'(DUMP_BASE) + cnt[7:0];
    assign hold_end = cnt == 16'(START_HOLD - 1);
    assign dump_end = cnt[7:0] == 8'(DUMP_LEN - 1);
    assign run_cap = (cycles + 16'd1) == TIMEOUT;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign dut_start = state != RUN;
    always_comb begin
        state_nx = state;
        ld_ready = 1'b0;
        mem_we = 1'b0;
        mem_addr = 8'h00;
        mem_wdata = 8'h00;
        out_valid = 1'b0;
        out_addr = 8'h00;
        out_data = 8'h00;
        case (state)
            IDLE: begin
`ifdef PROG_RUN_CTRL_CLEAR_EN
                if (go) state_nx = CLEAR;
`else
                if (go) state_nx = LOAD;
`endif
            end
`ifdef PROG_RUN_CTRL_CLEAR_EN
            CLEAR: begin
                mem_we = 1'b1;
                mem_addr = cnt[7:0];
                if (cnt[7:0] == 8'hFF) state_nx = LOAD;
            end
`endif
            LOAD: begin
                ld_ready = 1'b1;
                mem_we = ld_valid;
                mem_addr = ld_valid ? ld_addr : 8'h00;
                mem_wdata = ld_valid ? ld_data : 8'h00;
                if (ld_valid && ld_last) state_nx = START;
            end
            START: if (hold_end) state_nx = RUN;
            RUN: if (dut_halt || run_cap) state_nx = DUMP;
            DUMP: begin
                out_valid = 1'b1;
                mem_addr = dump_addr;
                out_addr = dump_addr;
                out_data = mem_rdata;
                if (out_ready && dump_end) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // a reset edge must not complete a memory write or a handshake
        if (Reset) begin
            ld_ready = 1'b0;
            mem_we = 1'b0;
            out_valid = 1'b0;
        end
    end
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            cnt <= 16'd0;
            cycles <= 16'd0;
            timeout <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= (state_nx != state) ? 16'd0 : (state != DUMP || out_ready) ? cnt + 16'd1 : cnt;
            if (state == IDLE && go) begin
                cycles <= 16'd0;
                timeout <= 1'b0;
            end
            if (state == START && hold_end) cycles <= 16'd0;
            if (state == RUN && !dut_halt) begin
                cycles <= cycles + 16'd1;
                if (run_cap) timeout <= 1'b1;
            end
        end
    end
endmodule

// File: doc/prog_run_ctrl.md
PROG_RUN_CTRL -- requirements
Module: prog_run_ctrl

Interface
REQ-001 Parameter DUMP_BASE, 30: first data-memory address dumped after halt.
REQ-002 Parameter DUMP_LEN, 30: number of bytes dumped, 1..256.
REQ-003 Parameter START_HOLD, 2: cycles dut_start is held high before release, at least 1.
REQ-004 Parameter TIMEOUT, 16'hFFFF: maximum RUN cycles before the run is abandoned.
REQ-005 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port Reset, input, 1: synchronous, active-high reset.
REQ-007 Port go, input, 1: run request, sampled in IDLE only.
REQ-008 Ports ld_valid/ld_last, input, 1 each; ld_addr/ld_data, input, 8 each: preload stream, with ld_last marking the final entry.
REQ-009 Port ld_ready, output, 1: preload entry accepted when ld_valid && ld_ready.
REQ-010 Ports mem_we, output, 1; mem_addr/mem_wdata, output, 8 each; mem_rdata, input, 8: data-memory port with combinational read of mem_addr.
REQ-011 Port dut_start, output, 1: drives the processor's start input (high holds it in reset).
REQ-012 Port dut_halt, input, 1: processor done flag.
REQ-013 Ports out_valid, output, 1; out_ready, input, 1; out_addr/out_data, output, 8 each: result dump stream.
REQ-014 Ports busy, output, 1; done, output, 1; timeout, output, 1; cycles, output, 16: run status.

Function
REQ-015 FSM states: IDLE, CLEAR, LOAD, START, RUN, DUMP, DONE; busy = 1 in every state except IDLE.
REQ-016 IDLE: go=1 clears cycles and timeout and moves to CLEAR (macro on) or LOAD (macro off); go in any other state is ignored.
REQ-017 CLEAR: mem_we=1, mem_wdata=0, mem_addr steps 0..255 one per cycle; after the write to 255 the FSM moves to LOAD (256 cycles total).
REQ-018 LOAD: ld_ready=1; on handshake mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in the same cycle (no extra latency); handshake with ld_last=1 moves to START.
REQ-019 LOAD with no handshake: mem_we=0, FSM waits indefinitely; duplicate addresses are written last-wins.
REQ-020 START: dut_start=1 for exactly START_HOLD cycles, then the FSM moves to RUN with dut_start=0; dut_halt is ignored in START.
REQ-021 RUN: dut_start=0; cycles is cleared on entry and increments each cycle dut_halt=0; in the first RUN cycle with dut_halt=1, cycles freezes and the FSM moves to DUMP.
REQ-022 RUN timeout: when cycles reaches TIMEOUT with dut_halt still 0, timeout=1, cycles holds TIMEOUT, and the FSM moves to DUMP; cycles never wraps.
REQ-023 DUMP: dut_start=1 (processor parked); index i starts at 0; mem_addr = out_addr = (DUMP_BASE+i) mod 256; out_data = mem_rdata; out_valid=1.
REQ-024 DUMP handshake: out_valid && out_ready advances i; out_addr and out_data are held stable while out_ready=0; the transfer with i=DUMP_LEN-1 moves the FSM to DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; cycles and timeout hold until the next accepted go.
REQ-026 dut_start=1 in every state except RUN; mem_we=0 except as stated in REQ-017 and REQ-018; ld_ready=0 outside LOAD; out_valid=0 outside DUMP.

Reset
REQ-027 Reset=1 at a clock edge forces IDLE from any state, including mid-LOAD, RUN, or DUMP; no pending write or dump beat completes.
REQ-028 Reset values: dut_start=1, busy=0, done=0, timeout=0, cycles=0, ld_ready=0, mem_we=0, out_valid=0, mem_addr=0, mem_wdata=0, out_addr=0, out_data=0 (out_data forced to 0 outside DUMP).
REQ-029 Reset takes priority over go, dut_halt, and every handshake in the same cycle.

Configuration
REQ-030 Macro PROG_RUN_CTRL_CLEAR_EN: when defined, the CLEAR state exists and zeroes all 256 bytes before LOAD; when undefined, CLEAR is not built and IDLE goes directly to LOAD, leaving prior memory contents intact.

Verification
REQ-031 Macro on; go; load {1:07, 0:FF, 3:00, 2:01, 5:00, 4:01 (last)} -> memory image is zero except these six bytes; START lasts exactly 2 cycles; then RUN begins.
REQ-032 dut_halt model rises in the 5th RUN cycle -> cycles=4, timeout=0; 30 beats with out_addr 30..59 and out_data equal to memory contents; done pulses once.
REQ-033 out_ready toggled randomly during DUMP -> no beat is lost or duplicated; out_addr/out_data stay stable while stalled.
REQ-034 TIMEOUT=10 and dut_halt held 0 -> timeout=1, cycles=10; dump still completes; done pulses.
REQ-035 DUMP_BASE=250, DUMP_LEN=10 -> out_addr sequence 250..255, 0..3 (wrap-around).
REQ-036 Reset asserted mid-RUN and mid-DUMP -> next cycle IDLE with all REQ-028 values; go asserted during RUN is ignored; macro off -> memory outside the loaded addresses keeps its prior contents.
